// File: rtl/button_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the
// pushbutton reader.
package button_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMING,
    ST_DOWN,
    ST_HELD,
    ST_RELEASING
  } state_t;

  // Defaults assume a 12 MHz clock: 20 ms debounce, 1 s long press, 200 ms repeat.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 240000;
  localparam int unsigned DEF_LONG_CYCLES     = 12000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 2400000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One spare bit so that terminal value + 1 is still representable.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/button_reader_if.sv
// Bundle of the raw button input and the debounced level/strobe outputs.
interface button_reader_if;

  logic btn_n;
  logic down;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;

  // Stimulus/consumer side: drives the raw button, observes the events.
  modport master (
    output btn_n,
    input  down, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

  // Reader side: samples the raw button, produces the events.
  modport slave (
    input  btn_n,
    output down, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit (or bit-independent) inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Each bit is synchronized on its own; no cross-bit coherence is implied.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/button_reader.sv
// Debounced pushbutton reader with press/release strobes, long-press detection
// and auto-repeat while held.
module button_reader
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic down,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W = int'(cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES));

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0] btn_sync;
  logic       btn_s;

  // Invert before synchronizing so the reset value of the flops means "released".
  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (~btn_n),
    .q  (btn_sync)
  );

  assign btn_s = btn_sync[0];

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             held_seen_reg;
  logic             down_reg;
  logic             press_reg;
  logic             release_reg;
  logic             long_reg;
  logic             repeat_reg;

  assign cnt_next = cnt_reg + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      held_seen_reg <= 1'b0;
      down_reg      <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      long_reg      <= 1'b0;
      repeat_reg    <= 1'b0;
    end else begin
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;
      repeat_reg  <= 1'b0;

      unique case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (btn_s) begin
            state_reg <= ST_ARMING;
            cnt_reg   <= CNT_ONE;
          end
        end

        ST_ARMING: begin
          if (!btn_s) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg >= DEB_LAST) begin
            state_reg     <= ST_DOWN;
            cnt_reg       <= '0;
            held_seen_reg <= 1'b0;
            down_reg      <= 1'b1;
            press_reg     <= 1'b1;
          end else begin
            cnt_reg <= cnt_next;
          end
        end

        ST_DOWN: begin
          if (!btn_s) begin
            state_reg <= ST_RELEASING;
            cnt_reg   <= CNT_ONE;
          end else if (cnt_next >= LONG_LAST) begin
            state_reg     <= ST_HELD;
            cnt_reg       <= '0;
            held_seen_reg <= 1'b1;
            long_reg      <= 1'b1;
          end else begin
            cnt_reg <= cnt_next;
          end
        end

        ST_HELD: begin
          if (!btn_s) begin
            state_reg <= ST_RELEASING;
            cnt_reg   <= CNT_ONE;
          end else if (cnt_next >= REP_LAST) begin
            cnt_reg    <= '0;
            repeat_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_next;
          end
        end

        ST_RELEASING: begin
          // A short release is a glitch: resume where we were, with a fresh timer.
          if (btn_s) begin
            state_reg <= held_seen_reg ? ST_HELD : ST_DOWN;
            cnt_reg   <= '0;
          end else if (cnt_reg >= DEB_LAST) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            held_seen_reg <= 1'b0;
            down_reg      <= 1'b0;
            release_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_next;
          end
        end

        default: begin
          state_reg     <= ST_IDLE;
          cnt_reg       <= '0;
          held_seen_reg <= 1'b0;
          down_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign down          = down_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_pulse    = long_reg;
  assign repeat_pulse  = repeat_reg;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: directed scenarios plus random press/release
// traffic, checked against a run-length / timestamp reference model.
module tb_button_reader;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_reader_if bif ();

  button_reader #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (bif.btn_n),
    .down         (bif.down),
    .press_pulse  (bif.press_pulse),
    .release_pulse(bif.release_pulse),
    .long_pulse   (bif.long_pulse),
    .repeat_pulse (bif.repeat_pulse)
  );

  always #5 clk = ~clk;

  // Edge counter: read at a negedge it is the index of the next posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe vector order: {press, release, long, repeat}
  typedef struct {
    int         cyc;
    logic [3:0] st;
  } ev_t;

  typedef struct {
    int   cyc;
    logic d;
  } lv_t;

  ev_t ev_q[$];
  lv_t lv_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: a level is accepted after DEB+1 consecutive synchronized samples
  // of the opposite value; long/repeat are timestamps measured from the last restart.
  logic [1:0] m_pipe;
  logic       m_acc;
  logic       m_held;
  logic       m_run_val;
  int         m_run_len;
  int         m_t_restart;

  function automatic void model_reset();
    m_pipe      = 2'b00;
    m_acc       = 1'b0;
    m_held      = 1'b0;
    m_run_val   = 1'b0;
    m_run_len   = 1;
    m_t_restart = 0;
  endfunction

  function automatic void model_step(input logic r, input logic b);
    logic       s;
    logic [3:0] st;
    int         e;
    ev_t        ev;
    lv_t        lv;
    e  = cyc;
    st = 4'b0000;
    if (r) begin
      model_reset();
    end else begin
      s         = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = ~b;
      if (s == m_run_val) m_run_len++;
      else begin
        m_run_val = s;
        m_run_len = 1;
      end
      if (!m_acc) begin
        if (s && m_run_len == DEB + 1) begin
          m_acc       = 1'b1;
          m_held      = 1'b0;
          m_t_restart = e;
          st          = 4'b1000;
        end
      end else if (!s) begin
        if (m_run_len == DEB + 1) begin
          m_acc = 1'b0;
          st    = 4'b0100;
        end
      end else if (m_run_len == 1) begin
        m_t_restart = e;
      end else if (!m_held && (e - m_t_restart) == LNG) begin
        m_held      = 1'b1;
        m_t_restart = e;
        st          = 4'b0010;
      end else if (m_held && ((e - m_t_restart) % REP) == 0) begin
        st = 4'b0001;
      end
    end
    if (st != 4'b0000) begin
      ev.cyc = e;
      ev.st  = st;
      ev_q.push_back(ev);
    end
    lv.cyc = e;
    lv.d   = m_acc;
    lv_q.push_back(lv);
  endfunction

  task automatic step(input logic r, input logic b);
    @(negedge clk);
    rst       = r;
    bif.btn_n = b;
    model_step(r, b);
  endtask

  task automatic seg(input logic b, input int n);
    for (int i = 0; i < n; i++) step(1'b0, b);
  endtask

  // Monitor: 1 time unit after each edge, compare outputs with what the model queued.
  logic [3:0] mon_st;
  ev_t        mon_ev;
  lv_t        mon_lv;

  always @(posedge clk) begin
    #1;
    mon_st = {bif.press_pulse, bif.release_pulse, bif.long_pulse, bif.repeat_pulse};
    if (lv_q.size() > 0 && lv_q[0].cyc == cyc - 1) begin
      mon_lv = lv_q.pop_front();
      checks++;
      if (bif.down !== mon_lv.d) begin
        errors++;
        $display("FAIL down cyc=%0d got=%b exp=%b", cyc - 1, bif.down, mon_lv.d);
      end
    end
    if (mon_st != 4'b0000) begin
      checks++;
      if (ev_q.size() == 0 || ev_q[0].cyc != cyc - 1) begin
        errors++;
        $display("FAIL strobe_unexpected cyc=%0d got=%b exp=0000", cyc - 1, mon_st);
      end else begin
        mon_ev = ev_q.pop_front();
        if (mon_st !== mon_ev.st) begin
          errors++;
          $display("FAIL strobe cyc=%0d got=%b exp=%b", cyc - 1, mon_st, mon_ev.st);
        end else begin
          $display("event cyc=%0d strobes(p,r,l,rep)=%b down=%b", cyc - 1, mon_st, bif.down);
        end
      end
    end else if (ev_q.size() > 0 && ev_q[0].cyc == cyc - 1) begin
      mon_ev = ev_q.pop_front();
      checks++;
      errors++;
      $display("FAIL strobe_missing cyc=%0d got=0000 exp=%b", cyc - 1, mon_ev.st);
    end
  end

  initial begin
    logic [4:0] outs;
    bif.btn_n = 1'b1;
    rst       = 1'b1;
    model_reset();
    repeat (3) step(1'b1, 1'b1);

    @(posedge clk);
    #2;
    outs = {bif.down, bif.press_pulse, bif.release_pulse, bif.long_pulse, bif.repeat_pulse};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outs[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out%0d got=%b exp=0", i, outs[i]);
      end
    end

    seg(1'b1, 5);
    // Clean press
    seg(1'b0, 12);
    seg(1'b1, 12);
    // Bounce shorter than the debounce window
    repeat (5) begin
      seg(1'b0, 3);
      seg(1'b1, 1);
    end
    seg(1'b1, 10);
    // Long press with auto-repeat
    seg(1'b0, 40);
    seg(1'b1, 12);
    // Release glitch while down
    seg(1'b0, 10);
    seg(1'b1, 3);
    seg(1'b0, 30);
    seg(1'b1, 12);
    // Reset while held
    seg(1'b0, 28);
    step(1'b1, 1'b0);
    seg(1'b0, 15);
    seg(1'b1, 12);

    // Random traffic: mix of bounces, presses, long holds and occasional resets
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        step(1'b1, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 2) == 0) begin
        seg(1'($urandom_range(0, 1)), int'($urandom_range(1, 50)));
      end else begin
        seg(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
      end
    end
    seg(1'b1, 15);

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d exp=0", ev_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
